// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: instruction field layout, class codes,
// FSM state encoding and the decoded control-word bundle.
package control_sequencer_pkg;

    localparam int IW = 12;
    localparam logic [2:0] ALU_PASS_B_DEF = 3'b111;

    localparam int CLS_MSB = 11;
    localparam int CLS_LSB = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 3;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

    localparam logic [2:0] CLS_NOP  = 3'b000;
    localparam logic [2:0] CLS_MOV  = 3'b001;
    localparam logic [2:0] CLS_LDI  = 3'b010;
    localparam logic [2:0] CLS_ALU  = 3'b011;
    localparam logic [2:0] CLS_HALT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] regsel;
        logic [2:0] alusel;
        logic       rin;
        logic       rout;
        logic       rain;
        logic       rcout;
        logic       genconst;
        logic       done;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] ir_cls(input logic [IW-1:0] ir);
        return ir[CLS_MSB:CLS_LSB];
    endfunction

    function automatic logic [2:0] ir_op(input logic [IW-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] ir_rx(input logic [IW-1:0] ir);
        return ir[RX_MSB:RX_LSB];
    endfunction

    function automatic logic [2:0] ir_ry(input logic [IW-1:0] ir);
        return ir[RY_MSB:RY_LSB];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction handshake plus datapath strobes between the sequencer and its datapath.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    regSel;
    logic [2:0]    aluSel;
    logic          Rin;
    logic          Rout;
    logic          RAin;
    logic          RCout;
    logic          genConst;
    logic          done;
    logic          halted;
    logic          illegal;

    // master is the sequencer itself; slave is the instruction source / datapath side
    modport master (
        input  instr, instr_valid,
        output instr_ready, regSel, aluSel, Rin, Rout, RAin, RCout, genConst,
               done, halted, illegal
    );

    modport slave (
        output instr, instr_valid,
        input  instr_ready, regSel, aluSel, Rin, Rout, RAin, RCout, genConst,
               done, halted, illegal
    );
endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// Purely combinational step decoder: (state, IR) -> datapath control word.
module ctrl_decode
    import control_sequencer_pkg::*;
#(
    parameter logic [2:0] ALU_PASS_B = ALU_PASS_B_DEF
) (
    input  state_e        state,
    input  logic [IW-1:0] ir,
    output ctrl_t         ctrl
);

    logic [2:0] cls;
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign cls = ir_cls(ir);
    assign op  = ir_op(ir);
    assign rx  = ir_rx(ir);
    assign ry  = ir_ry(ir);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_T1: begin
                case (cls)
                    CLS_NOP, CLS_HALT: ctrl.done = 1'b1;
                    CLS_MOV: begin
                        ctrl.regsel = ry;
                        ctrl.rout   = 1'b1;
                        ctrl.alusel = ALU_PASS_B;
                    end
                    // ry field carries the constant k for LDI
                    CLS_LDI: begin
                        ctrl.regsel   = ry;
                        ctrl.genconst = 1'b1;
                        ctrl.alusel   = ALU_PASS_B;
                    end
                    CLS_ALU: begin
                        ctrl.regsel = rx;
                        ctrl.rout   = 1'b1;
                        ctrl.rain   = 1'b1;
                    end
                    default: begin
                        ctrl.done    = 1'b1;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                case (cls)
                    CLS_MOV, CLS_LDI: begin
                        ctrl.regsel = rx;
                        ctrl.rcout  = 1'b1;
                        ctrl.rin    = 1'b1;
                        ctrl.done   = 1'b1;
                    end
                    CLS_ALU: begin
                        ctrl.regsel = ry;
                        ctrl.rout   = 1'b1;
                        ctrl.alusel = op;
                    end
                    default: ;
                endcase
            end
            ST_T3: begin
                if (cls == CLS_ALU) begin
                    ctrl.regsel = rx;
                    ctrl.rcout  = 1'b1;
                    ctrl.rin    = 1'b1;
                    ctrl.done   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per handshake into IR and
// steps the register/ALU datapath through T1..T3 as a Moore machine.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [2:0] ALU_PASS_B = ALU_PASS_B_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    control_sequencer_if.master   bus
);

    state_e        state_reg, state_next;
    logic [IW-1:0] ir_reg, ir_next;
    ctrl_t         ctrl;
    ctrl_t         ctrl_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    ir_next    = bus.instr;
                    state_next = ST_T1;
                end
            end
            ST_T1: begin
                case (ir_cls(ir_reg))
                    CLS_MOV, CLS_LDI, CLS_ALU: state_next = ST_T2;
                    CLS_HALT:                  state_next = ST_HALTED;
                    default:                   state_next = ST_IDLE;
                endcase
            end
            ST_T2:     state_next = (ir_cls(ir_reg) == CLS_ALU) ? ST_T3 : ST_IDLE;
            ST_T3:     state_next = ST_IDLE;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    ctrl_decode #(
        .ALU_PASS_B(ALU_PASS_B)
    ) u_decode (
        .state(state_reg),
        .ir   (ir_reg),
        .ctrl (ctrl)
    );

    // Everything is held low while reset is asserted, independent of the current state.
    assign ctrl_out        = rst ? ctrl : '0;
    assign bus.instr_ready = rst && (state_reg == ST_IDLE);
    assign bus.halted      = rst && (state_reg == ST_HALTED);
    assign bus.regSel      = ctrl_out.regsel;
    assign bus.aluSel      = ctrl_out.alusel;
    assign bus.Rin         = ctrl_out.rin;
    assign bus.Rout        = ctrl_out.rout;
    assign bus.RAin        = ctrl_out.rain;
    assign bus.RCout       = ctrl_out.rcout;
    assign bus.genConst    = ctrl_out.genconst;
    assign bus.done        = ctrl_out.done;
    assign bus.illegal     = ctrl_out.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: accepted instructions push their expected step sequence; a monitor
// pops one step per busy cycle and also checks results through a small datapath model.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    typedef struct {
        logic [2:0] regsel;
        logic [2:0] alusel;
        logic       rin, rout, rain, rcout, genconst, done, illegal;
        logic       halt;
        logic       wr;
        logic [2:0] wr_idx;
        logic [7:0] wr_val;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    step_t      exp_q[$];
    logic [7:0] ref_r[8];
    logic [7:0] dp_r[8];
    logic [7:0] dp_a, dp_c, dp_bus;
    int         checks = 0;
    int         errors = 0;
    int         just_pushed = 0;
    bit         exp_halted = 1'b0;

    function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~b;
            3'd6: return {b[6:0], 1'b0};
            default: return b;
        endcase
    endfunction

    // Bench-side datapath driven purely by the sequencer's strobes
    assign dp_bus = bus.Rout ? dp_r[bus.regSel] :
                    bus.RCout ? dp_c :
                    bus.genConst ? {5'b0, bus.regSel} : 8'h00;

    always @(posedge clk) begin
        if (bus.Rin) dp_r[bus.regSel] <= dp_bus;
        if (bus.RAin) dp_a <= dp_bus;
        if (bus.Rout || bus.genConst) dp_c <= alu_f(bus.aluSel, dp_a, dp_bus);
    end

    function automatic step_t blank();
        step_t s = '{default: '0};
        return s;
    endfunction

    function automatic logic [14:0] pack(input bit rdy, input bit hlt, input step_t s);
        return {rdy, hlt, s.regsel, s.alusel, s.rin, s.rout, s.rain, s.rcout, s.genconst, s.done, s.illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected per-step control words straight from the instruction rules
    task automatic push_instr(input logic [11:0] ins);
        logic [2:0] cls, op, rx, ry;
        step_t s1, s2, s3;
        int n0;
        cls = ins[11:9];
        op  = ins[8:6];
        rx  = ins[5:3];
        ry  = ins[2:0];
        s1 = blank();
        s2 = blank();
        s3 = blank();
        n0 = exp_q.size();
        case (cls)
            3'b000: begin s1.done = 1; exp_q.push_back(s1); end
            3'b100: begin s1.done = 1; s1.halt = 1; exp_q.push_back(s1); end
            3'b001, 3'b010: begin
                s1.regsel = ry;
                s1.alusel = 3'b111;
                if (cls == 3'b001) s1.rout = 1; else s1.genconst = 1;
                s2.regsel = rx; s2.rcout = 1; s2.rin = 1; s2.done = 1;
                s2.wr = 1; s2.wr_idx = rx;
                s2.wr_val = (cls == 3'b001) ? ref_r[ry] : {5'b0, ry};
                exp_q.push_back(s1);
                exp_q.push_back(s2);
            end
            3'b011: begin
                s1.regsel = rx; s1.rout = 1; s1.rain = 1;
                s2.regsel = ry; s2.rout = 1; s2.alusel = op;
                s3.regsel = rx; s3.rcout = 1; s3.rin = 1; s3.done = 1;
                s3.wr = 1; s3.wr_idx = rx; s3.wr_val = alu_f(op, ref_r[rx], ref_r[ry]);
                exp_q.push_back(s1);
                exp_q.push_back(s2);
                exp_q.push_back(s3);
            end
            default: begin s1.done = 1; s1.illegal = 1; exp_q.push_back(s1); end
        endcase
        just_pushed = exp_q.size() - n0;
        $display("accept instr=%03h cls=%0d op=%0d rx=%0d ry=%0d t=%0t", ins, cls, op, rx, ry, $time);
    endtask

    task automatic drive(input bit rst_v, input bit valid_v, input logic [11:0] ins);
        @(negedge clk);
        just_pushed     = 0;
        rst             = rst_v;
        bus.instr_valid = valid_v;
        bus.instr       = ins;
        if (!rst_v) begin
            exp_q.delete();
            exp_halted = 1'b0;
        end
        #1;
        if (rst_v && valid_v && bus.instr_ready) push_instr(ins);
    endtask

    task automatic run_instr(input logic [11:0] ins);
        drive(1, 1, ins);
        for (int i = 0; i < 3; i++) drive(1, 0, 12'($urandom));
    endtask

    initial begin : monitor
        step_t       s;
        logic [14:0] act_v, exp_v;
        bit          pend;
        logic [2:0]  pend_idx;
        logic [7:0]  pend_val;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (pend) begin
                chk("dp_write", {24'b0, dp_r[pend_idx]}, {24'b0, pend_val});
                pend = 1'b0;
            end
            act_v = {bus.instr_ready, bus.halted, bus.regSel, bus.aluSel, bus.Rin, bus.Rout,
                     bus.RAin, bus.RCout, bus.genConst, bus.done, bus.illegal};
            if (!rst) begin
                exp_v = '0;
            end else if (exp_q.size() > just_pushed) begin
                s = exp_q.pop_front();
                exp_v = pack(1'b0, 1'b0, s);
                if (s.halt) exp_halted = 1'b1;
                if (s.wr) begin
                    ref_r[s.wr_idx] = s.wr_val;
                    pend     = 1'b1;
                    pend_idx = s.wr_idx;
                    pend_val = s.wr_val;
                end
            end else begin
                exp_v = pack(!exp_halted, exp_halted, blank());
            end
            chk("outputs", {17'b0, act_v}, {17'b0, exp_v});
            chk("bus_onehot", ($countones({bus.Rout, bus.RCout, bus.genConst}) > 1) ? 1 : 0, 0);
            chk("rin_rain", (bus.Rin && bus.RAin) ? 1 : 0, 0);
        end
    end

    initial begin : stimulus
        bit r;
        for (int i = 0; i < 8; i++) begin
            ref_r[i] = 8'h00;
            dp_r[i]  = 8'h00;
        end
        dp_a = 8'h00;
        dp_c = 8'h00;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;

        // reset with valid asserted, then ready on first cycle after release
        drive(0, 1, 12'h0ff);
        drive(0, 1, 12'h0ff);
        drive(1, 0, 12'h000);

        run_instr(12'b010_000_011_101);     // LDI r3,5
        run_instr(12'b010_000_001_110);     // LDI r1,6
        run_instr(12'b010_000_010_011);     // LDI r2,3
        run_instr(12'b011_010_001_010);     // ALU r1 = r1 & r2
        run_instr(12'b011_000_011_011);     // ALU r3 = r3 + r3

        // back-to-back with valid held: MOV r4,r3 then NOPs
        drive(1, 1, 12'b001_000_100_011);
        for (int i = 0; i < 5; i++) drive(1, 1, 12'b000_000_000_000);
        drive(1, 0, 12'h000);
        drive(1, 0, 12'h000);

        // HALT then 10 cycles of offered instructions, then a one-cycle reset
        drive(1, 1, 12'b100_000_000_000);
        for (int i = 0; i < 10; i++) drive(1, 1, 12'b010_000_101_111);
        drive(0, 0, 12'h000);
        drive(1, 0, 12'h000);

        // reset in T2 of an ALU op, then an illegal class
        drive(1, 1, 12'b011_000_011_001);
        drive(1, 0, 12'h000);
        drive(0, 0, 12'h000);
        drive(1, 0, 12'h000);
        run_instr(12'b110_101_010_001);

        for (int i = 0; i < 2000; i++) begin
            r = !(($urandom_range(0, 59) == 0) || (exp_halted && ($urandom_range(0, 5) == 0)));
            drive(r, $urandom_range(0, 9) < 7, 12'($urandom));
        end

        for (int i = 0; i < 4; i++) drive(1, 0, 12'h000);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
